// File: rtl/buttons_pkg.sv
// Shared constants for the push-button peripheral: register word offsets and the
// address window claimed by the decoder.
package buttons_pkg;

  // Register word offsets, decoded from addr_i[3:2]
  localparam logic [1:0] BTN_OFS_STATE = 2'd0;
  localparam logic [1:0] BTN_OFS_EDGE  = 2'd1;
  localparam logic [1:0] BTN_OFS_RSVD  = 2'd2;
  localparam logic [1:0] BTN_OFS_MASK  = 2'd3;

  // Address window, shared with the address decoder
  localparam logic [31:0] BTN_BASE = 32'h7000_0000;
  localparam logic [31:0] BTN_SIZE = 32'h0000_1000;

endpackage

// File: rtl/btn_debounce.sv
// One-bit button conditioner: two-flop synchroniser followed by a persistence
// counter. A changed level is accepted only after it has been seen for
// DEBOUNCE_CYCLES consecutive edges; press_o pulses on the accepting 0 -> 1 edge.
module btn_debounce
  import buttons_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic raw_i,
  output logic state_o,
  output logic press_o
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  logic            sync1_q, sync2_q;
  logic            state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            accept;

  // Counter advances while the synchronised level disagrees with the accepted one
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    accept  = (sync2_q != state_q) && (cnt_q == CntMax);
    if (sync2_q != state_q) begin
      if (accept) begin
        state_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Synchroniser, counter and accepted state
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      state_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign state_o = state_q;
  // Combinational so the top can set EDGE on the same edge STATE rises
  assign press_o = accept & sync2_q;

endmodule

// File: rtl/buttons_ctrl.sv
// Memory-mapped push-button peripheral: debounced STATE, sticky W1C EDGE capture and
// registered read data (zero on non-read cycles so read buses can be OR-muxed).
// Optional macro BUTTONS_IRQ_EN adds the MASK register at offset 3 and irq_o.
module buttons_ctrl
  import buttons_pkg::*;
#(
  parameter int unsigned N_BUTTONS       = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter bit          ACTIVE_LOW      = 1'b0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 en_i,
  input  logic                 wr_en_i,
  input  logic [31:0]          addr_i,
  input  logic [31:0]          wdata_i,
  output logic [31:0]          rdata_o,
  input  logic [N_BUTTONS-1:0] buttons_i
`ifdef BUTTONS_IRQ_EN
  ,
  output logic                 irq_o
`endif
);

  logic [N_BUTTONS-1:0] raw;
  logic [N_BUTTONS-1:0] state;
  logic [N_BUTTONS-1:0] press;
  logic [N_BUTTONS-1:0] edge_q, edge_d;
  logic [N_BUTTONS-1:0] clr;
  logic [1:0]           ofs;
  logic                 wr_sel, rd_sel;
  logic [31:0]          rdata_d;
  logic                 unused_bits;

  assign ofs    = addr_i[3:2];
  assign wr_sel = en_i & wr_en_i;
  assign rd_sel = en_i & ~wr_en_i;

  // Only the word offset is decoded; the rest of the address is don't-care
  assign unused_bits = ^{addr_i[31:4], addr_i[1:0], wdata_i};

  // Normalise polarity so that 1 always means pressed
  assign raw = buttons_i ^ {N_BUTTONS{ACTIVE_LOW}};

  for (genvar i = 0; i < N_BUTTONS; i++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .raw_i  (raw[i]),
      .state_o(state[i]),
      .press_o(press[i])
    );
  end

  // EDGE next state: write-1-clear first, then OR in new presses so a set wins
  always_comb begin
    clr = '0;
    if (wr_sel && (ofs == BTN_OFS_EDGE)) begin
      clr = wdata_i[N_BUTTONS-1:0];
    end
    edge_d = (edge_q & ~clr) | press;
  end

  // EDGE register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      edge_q <= '0;
    end else begin
      edge_q <= edge_d;
    end
  end

`ifdef BUTTONS_IRQ_EN
  logic [N_BUTTONS-1:0] mask_q, mask_d;
  logic                 irq_d;

  // MASK write and interrupt next state
  always_comb begin
    mask_d = mask_q;
    if (wr_sel && (ofs == BTN_OFS_MASK)) begin
      mask_d = wdata_i[N_BUTTONS-1:0];
    end
    irq_d = |(edge_d & mask_d);
  end

  // MASK register and registered interrupt
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mask_q <= '0;
      irq_o  <= 1'b0;
    end else begin
      mask_q <= mask_d;
      irq_o  <= irq_d;
    end
  end
`endif

  // Read mux over pre-edge register values; zero unless this is a read
  always_comb begin
    rdata_d = '0;
    if (rd_sel) begin
      case (ofs)
        BTN_OFS_STATE: rdata_d[N_BUTTONS-1:0] = state;
        BTN_OFS_EDGE:  rdata_d[N_BUTTONS-1:0] = edge_q;
`ifdef BUTTONS_IRQ_EN
        BTN_OFS_MASK:  rdata_d[N_BUTTONS-1:0] = mask_q;
`endif
        default:       rdata_d = '0;
      endcase
    end
  end

  // Registered read data
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_o <= '0;
    end else begin
      rdata_o <= rdata_d;
    end
  end

endmodule

// File: tb/tb_buttons_ctrl.sv
// Directed self-checking bench for buttons_ctrl (N_BUTTONS=4, DEBOUNCE_CYCLES=4).
// The interrupt scenario is compiled only when BUTTONS_IRQ_EN is defined.
module tb_buttons_ctrl;

  localparam logic [31:0] Base = 32'h7000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        wr = 1'b0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic [31:0] rdata;
  logic [3:0]  buttons = 4'h0;
`ifdef BUTTONS_IRQ_EN
  logic        irq;
`endif

  int checks = 0;
  int failures = 0;

  buttons_ctrl #(
    .N_BUTTONS      (4),
    .DEBOUNCE_CYCLES(4),
    .ACTIVE_LOW     (1'b0)
  ) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .en_i     (en),
    .wr_en_i  (wr),
    .addr_i   (addr),
    .wdata_i  (wdata),
    .rdata_o  (rdata),
    .buttons_i(buttons)
`ifdef BUTTONS_IRQ_EN
    ,
    .irq_o    (irq)
`endif
  );

  always #5 clk = ~clk;

  // Advance one clock edge and settle just after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_read(input logic [1:0] ofs, output logic [31:0] d);
    en   = 1'b1;
    wr   = 1'b0;
    addr = Base | {28'h0, ofs, 2'b00};
    tick();
    d  = rdata;
    en = 1'b0;
  endtask

  task automatic do_write(input logic [1:0] ofs, input logic [31:0] d);
    en    = 1'b1;
    wr    = 1'b1;
    addr  = Base | {28'h0, ofs, 2'b00};
    wdata = d;
    tick();
    en    = 1'b0;
    wr    = 1'b0;
    wdata = 32'h0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    rst = 1'b1;
    tick();
    en = 1'b1;
    addr = Base;
    tick();
    checks++;
    if (rdata !== 32'h0) begin
      failures++;
      $display("FAIL reset_rdata: got %h expected %h", rdata, 32'h0);
    end
    rst = 1'b0;
    en  = 1'b0;
    tick();
    for (int o = 0; o < 4; o++) begin
      do_read(2'(o), d);
      checks++;
      if (d !== 32'h0) begin
        failures++;
        $display("FAIL reset_read_ofs%0d: got %h expected %h", o, d, 32'h0);
      end
    end
    do_write(2'd2, 32'hFFFF_FFFF);
    checks++;
    if (rdata !== 32'h0) begin
      failures++;
      $display("FAIL nonread_rdata_write: got %h expected %h", rdata, 32'h0);
    end
    do_write(2'd0, 32'hF);
    do_read(2'd2, d);
    checks++;
    if (d !== 32'h0) begin
      failures++;
      $display("FAIL reserved_read: got %h expected %h", d, 32'h0);
    end
    do_read(2'd0, d);
    checks++;
    if (d !== 32'h0) begin
      failures++;
      $display("FAIL state_readonly: got %h expected %h", d, 32'h0);
    end
    tick();
    checks++;
    if (rdata !== 32'h0) begin
      failures++;
      $display("FAIL nonread_rdata_idle: got %h expected %h", rdata, 32'h0);
    end
  endtask

  task automatic test_press();
    logic [31:0] d;
    logic [31:0] exp;
    // Level changes just after edge 0; STATE is visible on the read that follows edge 6
    buttons = 4'h4;
    en      = 1'b1;
    addr    = Base;
    for (int k = 1; k <= 7; k++) begin
      tick();
      exp = (k >= 7) ? 32'h4 : 32'h0;
      checks++;
      if (rdata !== exp) begin
        failures++;
        $display("FAIL press_latency_edge%0d: got %h expected %h", k, rdata, exp);
      end
    end
    // Misaligned address still selects EDGE
    addr = Base | 32'h6;
    tick();
    en = 1'b0;
    checks++;
    if (rdata !== 32'h4) begin
      failures++;
      $display("FAIL edge_after_press: got %h expected %h", rdata, 32'h4);
    end
    buttons = 4'h0;
    repeat (6) tick();
    do_read(2'd0, d);
    checks++;
    if (d !== 32'h0) begin
      failures++;
      $display("FAIL state_after_release: got %h expected %h", d, 32'h0);
    end
    do_read(2'd1, d);
    checks++;
    if (d !== 32'h4) begin
      failures++;
      $display("FAIL edge_sticky_release: got %h expected %h", d, 32'h4);
    end
  endtask

  task automatic test_bounce();
    logic [31:0] d;
    logic [13:0] pat;
    int bad;
    pat = 14'b00000001110111;  // bit i drives the level sampled at edge i+1
    do_write(2'd1, 32'hF);
    en   = 1'b1;
    addr = Base;
    bad  = 0;
    for (int i = 0; i < 14; i++) begin
      buttons[0] = pat[i];
      tick();
      if (rdata !== 32'h0) bad++;
    end
    tick();
    en = 1'b0;
    checks++;
    if (bad != 0 || rdata !== 32'h0) begin
      failures++;
      $display("FAIL bounce_state: nonzero_reads=%0d last=%h expected all %h", bad, rdata, 32'h0);
    end
    do_read(2'd1, d);
    checks++;
    if (d !== 32'h0) begin
      failures++;
      $display("FAIL bounce_edge: got %h expected %h", d, 32'h0);
    end
  endtask

  task automatic test_w1c();
    logic [31:0] d;
    buttons = 4'h5;
    repeat (6) tick();
    do_read(2'd1, d);
    checks++;
    if (d !== 32'h5) begin
      failures++;
      $display("FAIL edge_two_press: got %h expected %h", d, 32'h5);
    end
    do_write(2'd1, 32'h1);
    do_read(2'd1, d);
    checks++;
    if (d !== 32'h4) begin
      failures++;
      $display("FAIL w1c_bit0: got %h expected %h", d, 32'h4);
    end
    buttons = 4'h1;
    repeat (6) tick();
    do_write(2'd1, 32'h4);
    do_read(2'd1, d);
    checks++;
    if (d !== 32'h0) begin
      failures++;
      $display("FAIL w1c_bit2: got %h expected %h", d, 32'h0);
    end
    // Re-press button 2; the clearing write lands on its acceptance edge
    buttons = 4'h5;
    repeat (5) tick();
    do_write(2'd1, 32'h4);
    do_read(2'd1, d);
    checks++;
    if (d !== 32'h4) begin
      failures++;
      $display("FAIL set_wins: got %h expected %h", d, 32'h4);
    end
    do_read(2'd0, d);
    checks++;
    if (d !== 32'h5) begin
      failures++;
      $display("FAIL state_both: got %h expected %h", d, 32'h5);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] exp;
    buttons = 4'h0;
    repeat (6) tick();
    do_write(2'd1, 32'hF);
    buttons = 4'hF;
    tick();
    tick();
    rst = 1'b1;
    tick();
    en   = 1'b1;
    wr   = 1'b0;
    addr = Base;
    tick();
    checks++;
    if (rdata !== 32'h0) begin
      failures++;
      $display("FAIL rst_mid_rdata: got %h expected %h", rdata, 32'h0);
    end
    rst = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      tick();
      exp = (k >= 7) ? 32'hF : 32'h0;
      checks++;
      if (rdata !== exp) begin
        failures++;
        $display("FAIL rst_release_edge%0d: got %h expected %h", k, rdata, exp);
      end
    end
    addr = Base | 32'h4;
    tick();
    en = 1'b0;
    checks++;
    if (rdata !== 32'hF) begin
      failures++;
      $display("FAIL rst_held_edge: got %h expected %h", rdata, 32'hF);
    end
  endtask

`ifdef BUTTONS_IRQ_EN
  task automatic test_irq();
    logic [31:0] d;
    buttons = 4'h0;
    repeat (6) tick();
    do_write(2'd1, 32'hF);
    do_write(2'd3, 32'h2);
    do_read(2'd3, d);
    checks++;
    if (d !== 32'h2) begin
      failures++;
      $display("FAIL mask_read: got %h expected %h", d, 32'h2);
    end
    buttons = 4'h2;
    repeat (5) tick();
    checks++;
    if (irq !== 1'b0) begin
      failures++;
      $display("FAIL irq_before_press: got %b expected %b", irq, 1'b0);
    end
    tick();
    tick();
    checks++;
    if (irq !== 1'b1) begin
      failures++;
      $display("FAIL irq_assert: got %b expected %b", irq, 1'b1);
    end
    buttons = 4'hA;
    repeat (7) tick();
    do_read(2'd1, d);
    checks++;
    if (d !== 32'hA || irq !== 1'b1) begin
      failures++;
      $display("FAIL irq_unmasked_press: edge=%h irq=%b expected edge=%h irq=%b", d, irq,
               32'hA, 1'b1);
    end
    do_write(2'd1, 32'h2);
    tick();
    checks++;
    if (irq !== 1'b0) begin
      failures++;
      $display("FAIL irq_clear: got %b expected %b", irq, 1'b0);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_press();
    test_bounce();
    test_w1c();
    test_reset_mid();
`ifdef BUTTONS_IRQ_EN
    test_irq();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
